// File: rtl/crc_pkg.sv
// Shared widths, memory depth and arbiter state encoding for the CRC memory arbiter slice.
package crc_pkg;

  localparam int CRC_ADDR_W = 10;
  localparam int CRC_DATA_W = 8;
  localparam int MEM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not served last.
module rr_arb2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_a,  // 1: port A was the last one granted
  output logic [1:0] win      // one-hot, [0]=A, [1]=B
);

  always_comb begin
    win = 2'b00;
    if (req_a && req_b) begin
      win = last_a ? 2'b10 : 2'b01;
    end else if (req_a) begin
      win = 2'b01;
    end else if (req_b) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/crc_mem_arb.sv
// Shares one single-port synchronous RAM between a host (A, read/write) and a CRC
// scanner (B, read-only), and flags host writes that land inside a CRC pass.
module crc_mem_arb
  import crc_pkg::*;
#(
  parameter int ADDR_W = CRC_ADDR_W,
  parameter int DATA_W = CRC_DATA_W
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              scan_active,
  output logic              mod_flag
);

  arb_state_t        state_q, state_d;
  logic              last_a_q, last_a_d;
  logic              srv_a_q, srv_a_d;
  logic              srv_rd_q, srv_rd_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mod_flag_q, mod_flag_d;
  logic              scan_prev_q, scan_prev_d;
  logic [1:0]        win;
  logic              scan_rise;

  rr_arb2 u_rr_arb2 (
    .req_a  (a_req),
    .req_b  (b_req),
    .last_a (last_a_q),
    .win    (win)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    last_a_d    = last_a_q;
    srv_a_d     = srv_a_q;
    srv_rd_d    = srv_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      ACC: begin
        state_d    = RESP;
        a_rvalid_d = srv_a_q & srv_rd_q;
        b_rvalid_d = ~srv_a_q & srv_rd_q;
      end
      IDLE, RESP: begin
        state_d = IDLE;
        if (win[0]) begin
          state_d     = ACC;
          mem_en_d    = 1'b1;
          mem_we_d    = a_we;
          mem_addr_d  = a_addr;
          mem_wdata_d = a_wdata;
          a_gnt_d     = 1'b1;
          last_a_d    = 1'b1;
          srv_a_d     = 1'b1;
          srv_rd_d    = ~a_we;
        end else if (win[1]) begin
          state_d     = ACC;
          mem_en_d    = 1'b1;
          mem_addr_d  = b_addr;
          mem_wdata_d = '0;
          b_gnt_d     = 1'b1;
          last_a_d    = 1'b0;
          srv_a_d     = 1'b0;
          srv_rd_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A granted write during a pass beats the clear on the pass's first cycle.
    scan_rise   = scan_active & ~scan_prev_q;
    scan_prev_d = scan_active;
    mod_flag_d  = (a_gnt_q & mem_we_q & scan_active) | (mod_flag_q & ~scan_rise);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_a_q    <= 1'b0;
      srv_a_q     <= 1'b0;
      srv_rd_q    <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mod_flag_q  <= 1'b0;
      scan_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_a_q    <= last_a_d;
      srv_a_q     <= srv_a_d;
      srv_rd_q    <= srv_rd_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mod_flag_q  <= mod_flag_d;
      scan_prev_q <= scan_prev_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = mem_rdata;
  assign b_rdata   = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mod_flag  = mod_flag_q;

endmodule

// File: tb/tb_crc_mem_arb.sv
// Self-checking bench for crc_mem_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration, memory and modification-flag rules.
module tb_crc_mem_arb;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk50m = 1'b0;
  logic          rst_n  = 1'b1;
  logic          a_req, a_we, b_req, scan_active;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, mod_flag;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk50m = ~clk50m;

  // Single-port synchronous RAM, 1-cycle read latency.
  always @(posedge clk50m) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  crc_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk50m      (clk50m),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .scan_active (scan_active),
    .mod_flag    (mod_flag)
  );

  // Host write through the arbiter; returns at the falling edge of the RESP cycle.
  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int t = 0;
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
    do begin
      @(negedge clk50m);
      t++;
    end while (!a_gnt && t < 8);
    n_checks++;
    if (a_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL host_write_gnt: addr %h got a_gnt=%b after %0d cycles, expected 1", addr, a_gnt, t);
    end
    a_req = 1'b0; a_we = 1'b0;
    ref_mem[addr] = data;
    @(negedge clk50m);
  endtask

  task automatic test_reset();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0; scan_active = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, mod_flag} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b%b rvalid=%b%b en=%b we=%b mod=%b addr=%h wdata=%h, expected all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, mod_flag, mem_addr, mem_wdata);
    end
    @(negedge clk50m);
    @(negedge clk50m);
    rst_n = 1'b1;
    @(negedge clk50m);
    n_checks++;
    if ({a_gnt, b_gnt, mem_en, a_rvalid, b_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b%b en=%b rvalid=%b%b, expected all 0",
               a_gnt, b_gnt, mem_en, a_rvalid, b_rvalid);
    end
  endtask

  task automatic test_single_b_read();
    host_write(10'h3FF, 8'hA5);
    b_req = 1'b1; b_addr = 10'h3FF;
    @(negedge clk50m);
    n_checks++;
    if ({b_gnt, a_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL b_read_grant: got b_gnt=%b a_gnt=%b en=%b we=%b addr=%h, expected 1 0 1 0 3ff",
               b_gnt, a_gnt, mem_en, mem_we, mem_addr);
    end
    b_req = 1'b0;
    @(negedge clk50m);
    n_checks++;
    if ({b_rvalid, a_rvalid, a_gnt, b_gnt} !== 4'b1000 || b_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL b_read_data: got b_rvalid=%b a_rvalid=%b a_gnt=%b b_gnt=%b b_rdata=%h, expected 1 0 0 0 a5",
               b_rvalid, a_rvalid, a_gnt, b_gnt, b_rdata);
    end
    @(negedge clk50m);
    n_checks++;
    if ({b_rvalid, b_gnt, a_gnt} !== 3'b0) begin
      n_fail++;
      $display("FAIL b_read_done: got b_rvalid=%b b_gnt=%b a_gnt=%b, expected 0 0 0", b_rvalid, b_gnt, a_gnt);
    end
  endtask

  task automatic test_host_write();
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 8'h5C;
    @(negedge clk50m);
    n_checks++;
    if ({a_gnt, b_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 10'h010 || mem_wdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL host_write_acc: got a_gnt=%b b_gnt=%b en=%b we=%b addr=%h wdata=%h, expected 1 0 1 1 010 5c",
               a_gnt, b_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    a_req = 1'b0; a_we = 1'b0;
    ref_mem[10'h010] = 8'h5C;
    @(negedge clk50m);
    n_checks++;
    if ({a_rvalid, b_rvalid, a_gnt} !== 3'b0) begin
      n_fail++;
      $display("FAIL host_write_no_rvalid: got a_rvalid=%b b_rvalid=%b a_gnt=%b, expected 0 0 0",
               a_rvalid, b_rvalid, a_gnt);
    end
    b_req = 1'b1; b_addr = 10'h010;
    @(negedge clk50m);
    n_checks++;
    if (b_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL readback_gnt: got b_gnt=%b, expected 1", b_gnt);
    end
    b_req = 1'b0;
    @(negedge clk50m);
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL readback_data: got b_rvalid=%b b_rdata=%h, expected 1 5c", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
    b_req = 1'b1; b_addr = 10'h3FF;
    @(negedge clk50m);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk50m);
      case (i % 4)
        1:       exp = 4'b1000;
        2:       exp = 4'b0010;
        3:       exp = 4'b0100;
        default: exp = 4'b0001;
      endcase
      n_checks++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== exp) begin
        n_fail++;
        $display("FAIL contention_cycle%0d: got gnt/rvalid a,b=%b%b%b%b, expected %b",
                 i, a_gnt, b_gnt, a_rvalid, b_rvalid, exp);
      end
      if (exp[1]) begin
        n_checks++;
        if (a_rdata !== 8'h5C) begin
          n_fail++;
          $display("FAIL contention_a_data: got %h, expected 5c", a_rdata);
        end
      end
      if (exp[0]) begin
        n_checks++;
        if (b_rdata !== 8'hA5) begin
          n_fail++;
          $display("FAIL contention_b_data: got %h, expected a5", b_rdata);
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk50m);
    @(negedge clk50m);
  endtask

  task automatic test_mod_flag();
    scan_active = 1'b1;
    @(negedge clk50m);
    n_checks++;
    if (mod_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_start_clear: got %b, expected 0", mod_flag);
    end
    host_write(10'h020, 8'h11);
    n_checks++;
    if (mod_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_set_in_scan: got %b, expected 1", mod_flag);
    end
    scan_active = 1'b0;
    @(negedge clk50m);
    @(negedge clk50m);
    n_checks++;
    if (mod_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_hold_after_scan: got %b, expected 1", mod_flag);
    end
    scan_active = 1'b1;
    @(negedge clk50m);
    n_checks++;
    if (mod_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_clear_next_rise: got %b, expected 0", mod_flag);
    end
    scan_active = 1'b0;
    @(negedge clk50m);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h021; a_wdata = 8'h22;
    @(negedge clk50m);
    n_checks++;
    if (a_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_rise_write_gnt: got a_gnt=%b, expected 1", a_gnt);
    end
    a_req = 1'b0; a_we = 1'b0;
    ref_mem[10'h021] = 8'h22;
    scan_active = 1'b1;
    @(negedge clk50m);
    n_checks++;
    if (mod_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_set_beats_clear: got %b, expected 1", mod_flag);
    end
    @(negedge clk50m);
    n_checks++;
    if (mod_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_sticky: got %b, expected 1", mod_flag);
    end
    scan_active = 1'b0;
    @(negedge clk50m);
  endtask

  task automatic test_reset_mid_acc();
    b_req = 1'b1; b_addr = 10'h010;
    @(negedge clk50m);
    n_checks++;
    if (b_gnt !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_gnt: got b_gnt=%b en=%b, expected 1 1", b_gnt, mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, mod_flag} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got gnt=%b%b rvalid=%b%b en=%b we=%b mod=%b addr=%h, expected all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we, mod_flag, mem_addr);
    end
    @(negedge clk50m);
    n_checks++;
    if ({b_rvalid, b_gnt, mem_en} !== 3'b0) begin
      n_fail++;
      $display("FAIL abort_no_rvalid: got b_rvalid=%b b_gnt=%b en=%b, expected 0 0 0", b_rvalid, b_gnt, mem_en);
    end
    rst_n = 1'b1;
    @(negedge clk50m);
    n_checks++;
    if (b_gnt !== 1'b1 || b_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_regrant: got b_gnt=%b b_rvalid=%b, expected 1 0", b_gnt, b_rvalid);
    end
    b_req = 1'b0;
    @(negedge clk50m);
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL abort_reread: got b_rvalid=%b b_rdata=%h, expected 1 5c", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_full_scan();
    int got = 0;
    int nxt = 1;
    int bad = 0;
    logic [AW-1:0] rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) host_write(i[AW-1:0], DW'($urandom));
    n_checks++;
    if (mod_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_idle_writes: got %b, expected 0", mod_flag);
    end
    scan_active = 1'b1; b_req = 1'b1; b_addr = '0;
    for (int cyc = 0; cyc < 5000 && got < DEPTH; cyc++) begin
      @(negedge clk50m);
      if (b_rvalid) begin
        got++;
        n_checks++;
        if (b_rdata !== ref_mem[rd_addr]) begin
          n_fail++; bad++;
          if (bad < 6) $display("FAIL scan_data: addr %h got %h, expected %h", rd_addr, b_rdata, ref_mem[rd_addr]);
        end
      end
      if (b_gnt) begin
        rd_addr = b_addr;
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== b_addr || a_gnt !== 1'b0) begin
          n_fail++; bad++;
          if (bad < 6) $display("FAIL scan_access: got we=%b addr=%h a_gnt=%b, expected 0 %h 0", mem_we, mem_addr, a_gnt, b_addr);
        end
        if (nxt < DEPTH) begin
          b_addr = nxt[AW-1:0];
          nxt++;
        end else begin
          b_req = 1'b0;
        end
      end
    end
    n_checks++;
    if (got !== DEPTH) begin
      n_fail++;
      $display("FAIL scan_count: got %0d rvalid pulses, expected %0d", got, DEPTH);
    end
    n_checks++;
    if (mod_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_mod_flag: got %b, expected 0", mod_flag);
    end
    b_req = 1'b0; scan_active = 1'b0;
    @(negedge clk50m);
  endtask

  // Transaction-level model: a grant follows any request held through a cycle that was
  // not itself a grant cycle; ties go to the port not served last; reads return one cycle later.
  task automatic test_random();
    logic          prev_gnt = 1'b0, last_a = 1'b0, exp_mod = 1'b0, scan_old = 1'b0;
    logic          gnt_a_wr = 1'b0, rd_pend = 1'b0, rd_port_a = 1'b0;
    logic          exp_ga = 1'b0, exp_gb = 1'b0;
    logic [DW-1:0] rd_exp = '0, rdata;
    logic [AW-1:0] g_addr;
    int errs = 0;
    rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; scan_active = 1'b0;
    @(negedge clk50m);
    rst_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (!a_req || exp_ga) begin
        a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom); a_wdata = DW'($urandom);
      end
      if (!b_req || exp_gb) begin
        b_req = 1'($urandom_range(0, 1)); b_addr = AW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) scan_active = ~scan_active;
      if (gnt_a_wr && scan_active)         exp_mod = 1'b1;
      else if (scan_active && !scan_old)   exp_mod = 1'b0;
      scan_old = scan_active;

      @(negedge clk50m);
      exp_ga = 1'b0; exp_gb = 1'b0;
      if (!prev_gnt) begin
        if (a_req && b_req) begin
          exp_ga = !last_a; exp_gb = last_a;
        end else begin
          exp_ga = a_req; exp_gb = b_req;
        end
      end
      n_checks++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== {exp_ga, exp_gb, rd_pend && rd_port_a, rd_pend && !rd_port_a}) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_handshake k=%0d: got gnt/rvalid a,b=%b%b%b%b, expected %b%b%b%b", k,
                                a_gnt, b_gnt, a_rvalid, b_rvalid, exp_ga, exp_gb, rd_pend && rd_port_a, rd_pend && !rd_port_a);
      end
      if (rd_pend) begin
        rdata = rd_port_a ? a_rdata : b_rdata;
        n_checks++;
        if (rdata !== rd_exp) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_rdata k=%0d: got %h, expected %h", k, rdata, rd_exp);
        end
      end
      n_checks++;
      if (mod_flag !== exp_mod) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_mod_flag k=%0d: got %b, expected %b", k, mod_flag, exp_mod);
      end
      rd_pend = 1'b0; gnt_a_wr = 1'b0;
      if (exp_ga || exp_gb) begin
        g_addr = exp_ga ? a_addr : b_addr;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== g_addr || mem_we !== (exp_ga && a_we) ||
            (exp_ga && a_we && mem_wdata !== a_wdata)) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_mem_access k=%0d: got en=%b we=%b addr=%h wdata=%h, expected 1 %b %h",
                                  k, mem_en, mem_we, mem_addr, mem_wdata, exp_ga && a_we, g_addr);
        end
        last_a = exp_ga;
        if (exp_ga && a_we) begin
          ref_mem[a_addr] = a_wdata;
          gnt_a_wr = 1'b1;
        end else begin
          rd_pend = 1'b1; rd_port_a = exp_ga; rd_exp = ref_mem[g_addr];
        end
      end
      prev_gnt = exp_ga || exp_gb;
    end
    a_req = 1'b0; b_req = 1'b0; scan_active = 1'b0;
    @(negedge clk50m);
    @(negedge clk50m);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_b_read();
    test_host_write();
    test_contention();
    test_mod_flag();
    test_reset_mid_acc();
    test_full_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_mem_arb.md
CRC_MEM_ARB -- requirements
Module: crc_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk50m, input, 1: system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have host port A inputs a_req (1), a_we (1), a_addr (ADDR_W), a_wdata (DATA_W).
REQ-006 SHALL have host port A outputs a_gnt (1), a_rvalid (1), a_rdata (DATA_W).
REQ-007 SHALL have CRC scanner port B inputs b_req (1), b_addr (ADDR_W); B is read-only.
REQ-008 SHALL have CRC scanner port B outputs b_gnt (1), b_rvalid (1), b_rdata (DATA_W).
REQ-009 SHALL have memory outputs mem_en (1), mem_we (1), mem_addr (ADDR_W), mem_wdata (DATA_W), and input mem_rdata (DATA_W) from a single-port synchronous RAM with 1-cycle read latency.
REQ-010 SHALL have input scan_active (1): high while the scanner runs a CRC pass; output mod_flag (1): host wrote memory during the current pass.

Function
REQ-011 SHALL implement FSM states IDLE, ACC, RESP.
REQ-012 IDLE: no req -> stay IDLE; any req -> winner chosen, ACC next cycle.
REQ-013 ACC (exactly 1 cycle): mem_en=1, mem_addr/mem_we/mem_wdata registered from winner's inputs sampled at the arbitration edge; winner's gnt=1 this cycle only; always -> RESP.
REQ-014 RESP (exactly 1 cycle): if served access was a read, winner's rvalid=1 and rdata=mem_rdata this cycle; for writes no rvalid; any req -> new arbitration, ACC next; else -> IDLE.
REQ-015 Throughput: one access per 2 cycles; read latency req-sampled -> rvalid = 2 edges.
REQ-016 Requester SHALL hold req and its address/data stable until gnt; req sampled in RESP is treated as a new request, so a requester drops req in the cycle after gnt unless issuing another access.
REQ-017 Arbitration: only one req -> that port wins; both -> round-robin, port not served last wins; last-served register updates only on grant.
REQ-018 b_req ignores a_we semantics: mem_we=0 whenever B wins.
REQ-019 Non-winner's gnt and rvalid SHALL stay 0; rdata outputs may mirror mem_rdata but are valid only with rvalid.
REQ-020 mod_flag: cleared on the cycle scan_active rises (0->1); set when port A write is granted (ACC) while scan_active=1; sticky until next rising edge; if clear and set coincide, set wins.
REQ-021 mod_flag SHALL remain valid after scan_active falls, so the CRC result can be qualified.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, all gnt/rvalid/mem_en/mem_we=0, mem_addr/mem_wdata=0, mod_flag=0, last-served=B (A wins first tie), scan_active edge detector=0.
REQ-023 Reset mid-ACC/RESP SHALL abort the transaction with no gnt or rvalid issued afterward; first grant earliest 1 cycle after rst_n deasserts.

Structure
REQ-024 Package crc_pkg SHALL hold ADDR_W/DATA_W defaults, MEM_DEPTH=1024, and enum arb_state_t {IDLE, ACC, RESP}.
REQ-025 Round-robin decision SHALL be a sub-module rr_arb2 (inputs 2 reqs + last-served, outputs one-hot winner, combinational).
REQ-026 Implementation SHALL use one registered FSM, registered memory outputs, no latches.

Verification
REQ-027 Single B read: b_req=1, b_addr=0x3FF, RAM[0x3FF]=0xA5 -> b_gnt one cycle later, b_rvalid with b_rdata=0xA5 next cycle, a_gnt=0 throughout.
REQ-028 Contention: a_req and b_req high continuously from reset -> grants alternate A,B,A,B at 2-cycle spacing, A first.
REQ-029 Host write: a_req=1, a_we=1, a_addr=0x010, a_wdata=0x5C -> mem_en=1, mem_we=1, mem_addr=0x010, mem_wdata=0x5C in ACC; no a_rvalid; subsequent B read of 0x010 returns 0x5C.
REQ-030 mod_flag: scan_active rises, A writes during scan -> mod_flag=1, stays 1 after scan_active falls, clears on next rise; A write on rise cycle -> mod_flag=1.
REQ-031 Reset mid-ACC: assert rst_n low in ACC of B read -> no b_rvalid, outputs 0 immediately; after release pending b_req granted normally.
REQ-032 Full scan: scanner reads addresses 0..1023 while host idle -> 1024 b_rvalid pulses, data matches RAM image, mod_flag=0.
